// File: rtl/can_bit_source.sv
// CAN bus-side bit source: serialises a captured frame onto rx_bit with optional
// stuff-bit insertion, a free-running sample_point strobe and a recessive intermission.
module can_bit_source #(
    parameter int unsigned MAX_FRAME_LEN = 512,
    parameter int unsigned LEN_W         = 10,
    parameter int unsigned CLKS_PER_BIT  = 10,
    parameter int unsigned IDLE_BITS     = 11
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [MAX_FRAME_LEN-1:0] frame_bits,
    input  logic [LEN_W-1:0]         num_bits,
    input  logic                     stuff_en,
    input  logic [LEN_W-1:0]         stuff_stop,
    output logic                     rx_bit,
    output logic                     sample_point,
    output logic                     busy,
    output logic                     done,
    output logic [LEN_W-1:0]         bits_sent,
    output logic [LEN_W-1:0]         stuff_count
);

    localparam int unsigned TMR_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDLE_W = $clog2(IDLE_BITS + 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_BITS - 1);
    localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(MAX_FRAME_LEN);

    typedef enum logic [1:0] {IDLE, ARMED, SEND, INTERMISSION} state_t;

    state_t                   state;
    logic [TMR_W-1:0]         timer;
    logic [MAX_FRAME_LEN-1:0] frame_q;
    logic [LEN_W-1:0]         num_q;
    logic [LEN_W-1:0]         stop_q;
    logic                     stuff_en_q;
    logic [LEN_W-1:0]         src_cnt;
    logic                     run_level;
    logic [2:0]               run_len;
    logic [IDLE_W-1:0]        idle_cnt;

    logic len_ok;
    logic src_bit;
    logic src_counts;

    assign len_ok     = (num_bits != '0) && (num_bits <= MAX_LEN);
    assign src_bit    = frame_q[MAX_FRAME_LEN-1];
    assign src_counts = stuff_en_q && (src_cnt < stop_q);

    // Free-running bit timer; sample_point marks the last cycle of each bit time.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer        <= '0;
            sample_point <= 1'b0;
        end else begin
            sample_point <= (timer == TMR_LAST);
            timer        <= (timer == TMR_LAST) ? '0 : timer + TMR_W'(1);
        end
    end

    // Frame sequencer; every line-level change happens on the edge where sample_point drops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rx_bit      <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            bits_sent   <= '0;
            stuff_count <= '0;
            frame_q     <= '0;
            num_q       <= '0;
            stop_q      <= '0;
            stuff_en_q  <= 1'b0;
            src_cnt     <= '0;
            run_level   <= 1'b1;
            run_len     <= '0;
            idle_cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    rx_bit <= 1'b1;
                    if (start) begin
                        bits_sent   <= '0;
                        stuff_count <= '0;
                        if (len_ok) begin
                            // Left-align so the first source bit always sits at the MSB.
                            frame_q    <= frame_bits << (MAX_LEN - num_bits);
                            num_q      <= num_bits;
                            stop_q     <= stuff_stop;
                            stuff_en_q <= stuff_en;
                            src_cnt    <= '0;
                            run_len    <= '0;
                            busy       <= 1'b1;
                            state      <= ARMED;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ARMED, SEND: begin
                    if (sample_point) begin
                        if (run_len == 3'd5) begin
                            rx_bit      <= ~run_level;
                            run_level   <= ~run_level;
                            run_len     <= 3'd1;
                            stuff_count <= stuff_count + LEN_W'(1);
                            bits_sent   <= bits_sent + LEN_W'(1);
                        end else if (src_cnt < num_q) begin
                            rx_bit    <= src_bit;
                            frame_q   <= frame_q << 1;
                            src_cnt   <= src_cnt + LEN_W'(1);
                            bits_sent <= bits_sent + LEN_W'(1);
                            state     <= SEND;
                            // Bits past the stuffing region break any run for good.
                            if (!src_counts) begin
                                run_len <= '0;
                            end else if ((run_len != '0) && (src_bit == run_level)) begin
                                run_len <= run_len + 3'd1;
                            end else begin
                                run_level <= src_bit;
                                run_len   <= 3'd1;
                            end
                        end else begin
                            rx_bit   <= 1'b1;
                            idle_cnt <= '0;
                            state    <= INTERMISSION;
                        end
                    end
                end
                INTERMISSION: begin
                    rx_bit <= 1'b1;
                    if (sample_point) begin
                        if (idle_cnt == IDLE_LAST) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            idle_cnt <= idle_cnt + IDLE_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_can_bit_source.sv
// Bench for can_bit_source: frame-level timeline model (edge count since reset,
// precomputed line-bit queue) checked against the DUT on every falling clock edge.
module tb_can_bit_source;

    localparam int unsigned MAXL = 512;
    localparam int unsigned LW   = 10;
    localparam int unsigned CPB  = 10;
    localparam int unsigned IDLE = 11;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [MAXL-1:0] frame_bits = '0;
    logic [LW-1:0]   num_bits = '0;
    logic            stuff_en = 1'b0;
    logic [LW-1:0]   stuff_stop = '0;
    logic            rx_bit;
    logic            sample_point;
    logic            busy;
    logic            done;
    logic [LW-1:0]   bits_sent;
    logic [LW-1:0]   stuff_count;

    can_bit_source #(
        .MAX_FRAME_LEN(MAXL), .LEN_W(LW), .CLKS_PER_BIT(CPB), .IDLE_BITS(IDLE)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .frame_bits(frame_bits),
        .num_bits(num_bits), .stuff_en(stuff_en), .stuff_stop(stuff_stop),
        .rx_bit(rx_bit), .sample_point(sample_point), .busy(busy), .done(done),
        .bits_sent(bits_sent), .stuff_count(stuff_count)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;

    // Model: mode 0 = nothing since reset, 1 = rejected start, 2 = frame accepted.
    int kcount = 0;
    int mode = 0;
    int ks = 0, kb = 0, done_edge = 0;
    int m_len = 0, m_stuff_total = 0;
    bit m_line[$];
    int m_sc_prefix[$];

    localparam logic [33:0] F1 = 34'b0100010010010100000000000011111111;
    localparam logic [36:0] F1_STUFFED = 37'b0100010010010100000100000100111110111;

    // Line sequence straight from the stuffing rule: after 5 equal contributing bits, append the complement.
    function automatic void build_line(input logic [MAXL-1:0] fb, input int n, input bit en, input int stop);
        int run;
        bit lvl;
        int sc;
        bit b;
        m_line.delete();
        m_sc_prefix.delete();
        run = 0; lvl = 1'b0; sc = 0;
        for (int i = 0; i < n; i++) begin
            b = fb[n-1-i];
            m_line.push_back(b);
            m_sc_prefix.push_back(sc);
            if (en && i < stop) begin
                if (run > 0 && b == lvl) run++;
                else begin lvl = b; run = 1; end
                if (run == 5) begin
                    lvl = ~lvl; sc++; run = 1;
                    m_line.push_back(lvl);
                    m_sc_prefix.push_back(sc);
                end
            end else begin
                run = 0;
            end
        end
        m_len = m_line.size();
        m_stuff_total = sc;
    endfunction

    function automatic bit model_idle(input int k);
        if (mode == 2) return k > done_edge;
        return 1'b1;
    endfunction

    // Model update on each rising edge (k = edges since reset release).
    initial begin
        int d;
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                kcount = 0;
                mode = 0;
            end else begin
                kcount++;
                if (start && model_idle(kcount)) begin
                    ks = kcount;
                    if (num_bits == '0 || int'(num_bits) > MAXL) begin
                        mode = 1;
                    end else begin
                        mode = 2;
                        build_line(frame_bits, int'(num_bits), stuff_en, int'(stuff_stop));
                        d = (1 + CPB - (ks % CPB)) % CPB;
                        if (d == 0) d = CPB;
                        kb = ks + d;
                        done_edge = kb + (m_len + IDLE) * CPB;
                    end
                end
            end
        end
    end

    // Per-cycle compare of every output against the model timeline.
    initial begin
        bit e_rx, e_sp, e_busy, e_done;
        int e_bs, e_sc, k, i;
        forever begin
            @(negedge clock);
            k = kcount;
            e_sp = (k >= 1) && (k % CPB == 0);
            e_rx = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_bs = 0; e_sc = 0;
            if (mode == 1) begin
                e_done = (k == ks);
            end else if (mode == 2) begin
                e_busy = (k >= ks) && (k < done_edge);
                e_done = (k == done_edge);
                if (k >= kb) begin
                    i = (k - kb) / CPB;
                    if (i < m_len) begin
                        e_rx = m_line[i]; e_bs = i + 1; e_sc = m_sc_prefix[i];
                    end else begin
                        e_bs = m_len; e_sc = m_stuff_total;
                    end
                end
            end
            n_cmp++;
            if (rx_bit !== e_rx || sample_point !== e_sp || busy !== e_busy || done !== e_done ||
                int'(bits_sent) != e_bs || int'(stuff_count) != e_sc) begin
                n_bad++;
                $display("FAIL cycle k=%0d: rx/sp/busy/done=%b%b%b%b want %b%b%b%b bits_sent=%0d want %0d stuff_count=%0d want %0d",
                         k, rx_bit, sample_point, busy, done, e_rx, e_sp, e_busy, e_done,
                         bits_sent, e_bs, stuff_count, e_sc);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    // Caller is at a falling edge; start is seen on the next rising edge, then inputs are scrambled.
    task automatic send(input logic [MAXL-1:0] fb, input int n, input bit en, input int stop, output bit done_seen);
        frame_bits = fb; num_bits = LW'(n); stuff_en = en; stuff_stop = LW'(stop); start = 1'b1;
        @(negedge clock);
        done_seen = done;
        start = 1'b0;
        frame_bits = ~fb;
        num_bits = LW'($urandom_range(0, 1023));
        stuff_en = ~en;
        stuff_stop = LW'($urandom_range(0, 1023));
    endtask

    task automatic wait_done(input string name);
        int budget;
        bit ok;
        budget = (m_len + IDLE + 3) * CPB + 20;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) begin ok = 1'b1; break; end
            @(negedge clock);
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: no done within %0d cycles", name, budget);
        end
    endtask

    function automatic logic [MAXL-1:0] gen_frame();
        logic [MAXL-1:0] f;
        bit lvl;
        int i, r;
        f = '0;
        lvl = 1'($urandom_range(0, 1));
        i = 0;
        while (i < int'(MAXL)) begin
            r = int'($urandom_range(1, 8));
            for (int j = 0; j < r && i < int'(MAXL); j++) begin
                f[i] = lvl;
                i++;
            end
            lvl = ~lvl;
        end
        return f;
    endfunction

    initial begin
        logic [MAXL-1:0] f1, fr;
        logic [36:0] packed_line;
        bit ds;
        int n, stop, w, target;
        bit en;

        f1 = '0;
        f1[33:0] = F1;

        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_rx", int'(rx_bit), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_bits_sent", int'(bits_sent), 0);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        // Plain frame, no stuffing.
        send(f1, 34, 1'b0, 34, ds);
        check("t1_model_len", m_len, 34);
        wait_done("t1_done");
        check("t1_done_latency", kcount - kb, 45 * int'(CPB));
        check("t1_bits_sent", int'(bits_sent), 34);
        check("t1_stuff_count", int'(stuff_count), 0);

        // Back-to-back: stuffing over the whole frame.
        send(f1, 34, 1'b1, 34, ds);
        packed_line = '0;
        for (int i = 0; i < m_len && i < 37; i++) packed_line[36-i] = m_line[i];
        check("t2_model_len", m_len, 37);
        check("t2_model_line", int'(packed_line == F1_STUFFED), 1);
        wait_done("t2_done");
        check("t2_done_latency", kcount - kb, 48 * int'(CPB));
        check("t2_bits_sent", int'(bits_sent), 37);
        check("t2_stuff_count", int'(stuff_count), 3);

        // Stuffing region ends at index 20.
        send(f1, 34, 1'b1, 20, ds);
        check("t3_model_stuff", m_stuff_total, 1);
        wait_done("t3_done");
        check("t3_bits_sent", int'(bits_sent), 35);
        check("t3_stuff_count", int'(stuff_count), 1);

        // Rejected lengths: done next cycle, never busy.
        repeat (3) @(negedge clock);
        send(f1, 0, 1'b0, 0, ds);
        check("t4_len0_done", int'(ds), 1);
        check("t4_len0_busy", int'(busy), 0);
        send(f1, 600, 1'b1, 5, ds);
        check("t4_len600_done", int'(ds), 1);
        check("t4_len600_bits_sent", int'(bits_sent), 0);

        // Start pulsed mid-frame must be ignored.
        repeat (3) @(negedge clock);
        done_cnt = 0;
        send(f1, 34, 1'b0, 34, ds);
        repeat (100) @(negedge clock);
        send(~f1, 20, 1'b1, 5, ds);
        wait_done("t5_done");
        check("t5_bits_sent", int'(bits_sent), 34);
        repeat (30) @(negedge clock);
        check("t5_done_count", done_cnt, 1);

        // Reset at bit 10, then restart.
        done_cnt = 0;
        send(f1, 34, 1'b0, 34, ds);
        target = kb + 10 * int'(CPB) + 4;
        for (int i = 0; i < 2000 && kcount < target; i++) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_rx", int'(rx_bit), 1);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_sp", int'(sample_point), 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("t6_no_done_after_abort", done_cnt, 0);
        send(f1, 34, 1'b0, 34, ds);
        wait_done("t6_done");
        check("t6_done_latency", kcount - kb, 45 * int'(CPB));
        check("t6_bits_sent", int'(bits_sent), 34);
        @(negedge clock);
        check("t6_done_count", done_cnt, 1);

        // Randomized frames with random gaps and ignored mid-frame starts.
        for (int t = 0; t < 16; t++) begin
            fr = gen_frame();
            if (t == 5) n = int'(MAXL);
            else if (t == 9) n = 1;
            else n = int'($urandom_range(1, 80));
            en = 1'($urandom_range(0, 3) != 0);
            stop = int'($urandom_range(0, n + 3));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 25)) @(negedge clock);
            send(fr, n, en, stop, ds);
            if ($urandom_range(0, 2) == 0) begin
                w = int'($urandom_range(1, m_len * int'(CPB) - 1));
                repeat (w) @(negedge clock);
                send(gen_frame(), int'($urandom_range(1, 80)), 1'b1, 40, ds);
            end
            wait_done("rand_done");
        end
        repeat (20) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
